note_recorder: RTL and testbench
================================

# note_recorder

Parametrised record/replay engine for keyboard note codes. It samples the live PS/2 key code at a fixed sample rate into an on-chip buffer while recording, and tracks the recorded length. On request it replays that length at the same rate, once or looped, and emits a note-off code when the take ends or is aborted. It sits between the PS/2 decoder and the tone generator's note mux.

## Interface
Parameters:
- DATA_W, 8, width of a note code
- DEPTH, 128, buffer entries; power of two, ≥2
- CLK_HZ, 5_000_000, clock frequency
- SAMPLE_HZ, 16, sample/replay rate; DIV = CLK_HZ/SAMPLE_HZ (integer, ≥2)
- NOTE_OFF, 0, code driven when not replaying

Ports (AW = $clog2(DEPTH)):
- clk_5MHz  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- record  in  1  level; high = record
- replay  in  1  level; high = replay
- loop  in  1  level; high = restart replay at end of take
- ps2_asci  in  DATA_W  live key code
- record_asci  out  DATA_W  replayed code, NOTE_OFF otherwise
- playing  out  1  high while in PLAY
- rec_len  out  AW+1  entries in current take, 0..DEPTH
- full  out  1  rec_len == DEPTH

## Operation
- Reset values: state IDLE; record_asci=NOTE_OFF; playing=0; rec_len=0; full=0; pointers and divider 0. Buffer contents are not reset.
- Tick: one-cycle internal pulse, every DIV cycles. The divider clears to 0 on every state change, so the first tick after entering a state is DIV cycles later.
- States:
  - IDLE -> REC when record=1. On entry: rec_len=0, wr_ptr=0. This discards the old take.
  - IDLE -> PLAY when record=0, replay=1 and rec_len>0. On entry: rd_ptr=0. With rec_len=0 the block stays in IDLE.
  - REC: on each tick with rec_len<DEPTH, mem[wr_ptr]=ps2_asci, wr_ptr++, rec_len++. When full, ticks are ignored; there is no wrap and no overwrite. record=0 -> IDLE with rec_len kept.
  - PLAY: on each tick, record_asci=mem[rd_ptr].
    - If rd_ptr==rec_len-1: with loop=1, rd_ptr=0. With loop=0, set end flag and stay in PLAY.
    - Otherwise rd_ptr++.
    - On the next tick after the end flag: record_asci=NOTE_OFF, then -> IDLE.
  - PLAY aborts: replay=0 -> IDLE and record_asci=NOTE_OFF. record=1 has priority: -> REC and record_asci=NOTE_OFF.
- Priority: record over replay in every state. Both high in IDLE -> REC.
- loop is sampled at each end-of-take tick. Dropping loop mid-take ends after the current pass.
- rd_ptr/wr_ptr are AW bits. rec_len is AW+1 bits, so DEPTH is representable.

## Timing
- State changes one cycle after the controlling input is sampled high or low. record/replay are assumed synchronous to clk_5MHz.
- Buffer read is synchronous. record_asci updates in the cycle after the tick, then holds until the next update.
- playing is registered and equals (state==PLAY).
- full is combinational from rec_len, or registered with identical timing to rec_len.
- A write and rec_len increment happen in the cycle after the tick.
- Reset mid-operation: all outputs go to reset values immediately. The take is lost because rec_len=0.

## Structure
- Package note_rec_pkg: state enum {IDLE, REC, PLAY} and the NOTE_OFF default constant.
- Sub-module sample_tick_gen (parameter DIV; ports clk_5MHz, rst_n, clr, tick) holds the divider. The top level keeps the FSM, pointers, rec_len and the buffer, an inferred simple-dual-port RAM.

## Test plan
All scenarios use DEPTH=4, CLK_HZ=64, SAMPLE_HZ=16, so DIV=4.
- Record 3 ticks with ps2_asci=8'h41, 8'h42, 8'h43, then drop record -> rec_len=3, full=0. Replay, loop=0 -> record_asci=41, 42, 43 at 4-cycle spacing, then NOTE_OFF 4 cycles later; playing falls with it.
- Record 6 ticks with codes 1..6 -> rec_len=4, full=1. Replay yields 1, 2, 3, 4, so no overwrite occurred.
- Take of 2 (8'h10, 8'h20), loop=1 -> 10, 20, 10, 20, … Clear loop during the second pass -> ends after that pass's 20, then NOTE_OFF.
- During PLAY, assert record -> record_asci=NOTE_OFF next cycle, state REC, rec_len=0. With replay=1 and rec_len=0 in IDLE, the block stays IDLE and playing=0.
- Assert rst_n=0 mid-PLAY -> record_asci=NOTE_OFF, playing=0, rec_len=0 immediately. Release, then replay=1 -> no playback.

Source files
------------

// File: rtl/note_rec_pkg.sv
// rtl/note_rec_pkg.sv - shared state encoding and defaults for the note recorder
package note_rec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int NOTE_OFF_DEFAULT = 0;

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - sample-rate divider producing a one-cycle tick every DIV cycles
module sample_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_5MHz,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // clr realigns the phase so the first tick in a new state lands DIV cycles in
  always_ff @(posedge clk_5MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - record/replay engine for PS/2 note codes at a fixed sample rate
module note_recorder
  import note_rec_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 128,
  parameter int                CLK_HZ    = 5_000_000,
  parameter int                SAMPLE_HZ = 16,
  parameter logic [DATA_W-1:0] NOTE_OFF  = DATA_W'(NOTE_OFF_DEFAULT)
) (
  input  logic                         clk_5MHz,
  input  logic                         rst_n,
  input  logic                         record,
  input  logic                         replay,
  input  logic                         loop,
  input  logic [DATA_W-1:0]            ps2_asci,
  output logic [DATA_W-1:0]            record_asci,
  output logic                         playing,
  output logic [$clog2(DEPTH):0]       rec_len,
  output logic                         full
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  state_t              state;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       last_idx;
  logic                end_flag;
  logic                tick;
  logic                clr;
  logic                we;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   mem [DEPTH];

  sample_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk_5MHz (clk_5MHz),
    .rst_n    (rst_n),
    .clr      (clr),
    .tick     (tick)
  );

  assign full     = (rec_len == DEPTH_L);
  assign last_idx = rec_len[AW-1:0] - AW'(1);
  assign we       = (state == REC) && record && tick && !full;

  // Mirrors the FSM transition conditions so the divider restarts with each state
  always_comb begin
    clr = 1'b0;
    case (state)
      IDLE:    clr = record || (replay && rec_len != '0);
      REC:     clr = !record;
      PLAY:    clr = record || !replay || (tick && end_flag);
      default: clr = 1'b0;
    endcase
  end

  // Buffer is not reset; read port follows rd_ptr so data is ready before each tick
  always_ff @(posedge clk_5MHz) begin
    if (we) begin
      mem[wr_ptr] <= ps2_asci;
    end
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk_5MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      record_asci <= NOTE_OFF;
      playing     <= 1'b0;
      rec_len     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      end_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (record) begin
            state   <= REC;
            rec_len <= '0;
            wr_ptr  <= '0;
          end else if (replay && rec_len != '0) begin
            state    <= PLAY;
            rd_ptr   <= '0;
            end_flag <= 1'b0;
            playing  <= 1'b1;
          end
        end

        REC: begin
          if (!record) begin
            state <= IDLE;
          end else if (we) begin
            wr_ptr  <= wr_ptr + AW'(1);
            rec_len <= rec_len + (AW + 1)'(1);
          end
        end

        PLAY: begin
          if (record) begin
            state       <= REC;
            rec_len     <= '0;
            wr_ptr      <= '0;
            record_asci <= NOTE_OFF;
            playing     <= 1'b0;
            end_flag    <= 1'b0;
          end else if (!replay) begin
            state       <= IDLE;
            record_asci <= NOTE_OFF;
            playing     <= 1'b0;
            end_flag    <= 1'b0;
          end else if (tick) begin
            if (end_flag) begin
              state       <= IDLE;
              record_asci <= NOTE_OFF;
              playing     <= 1'b0;
              end_flag    <= 1'b0;
            end else begin
              record_asci <= rd_data;
              // loop is only consulted here, so clearing it lets the current pass finish
              if (rd_ptr == last_idx) begin
                if (loop) begin
                  rd_ptr <= '0;
                end else begin
                  end_flag <= 1'b1;
                end
              end else begin
                rd_ptr <= rd_ptr + AW'(1);
              end
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - scoreboard bench for note_recorder at DEPTH=4, DIV=4
module tb_note_recorder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk_5MHz;
  logic              rst_n;
  logic              record;
  logic              replay;
  logic              loop;
  logic [DATA_W-1:0] ps2_asci;
  logic [DATA_W-1:0] record_asci;
  logic              playing;
  logic [2:0]        rec_len;
  logic              full;

  note_recorder #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .CLK_HZ    (64),
    .SAMPLE_HZ (16),
    .NOTE_OFF  (8'h00)
  ) dut (
    .clk_5MHz    (clk_5MHz),
    .rst_n       (rst_n),
    .record      (record),
    .replay      (replay),
    .loop        (loop),
    .ps2_asci    (ps2_asci),
    .record_asci (record_asci),
    .playing     (playing),
    .rec_len     (rec_len),
    .full        (full)
  );

  typedef struct {
    logic [7:0] code;
    logic       play;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] take_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         mark = 0;
  logic       armed = 1'b0;
  logic [7:0] prev_asci = 8'h00;

  initial clk_5MHz = 1'b0;
  always #5 clk_5MHz = ~clk_5MHz;
  always @(posedge clk_5MHz) cyc <= cyc + 1;

  // Pops one expectation per change of record_asci; gap is cycles since the previous change or mark
  always @(negedge clk_5MHz) begin
    if (armed && record_asci !== prev_asci) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_output: got %h playing=%b at cycle %0d", record_asci, playing, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests_run++;
        if (record_asci !== e.code || playing !== e.play) begin
          tests_failed++;
          $display("FAIL sb_value: got %h/%b expected %h/%b", record_asci, playing, e.code, e.play);
        end
        if (e.gap != 0) begin
          tests_run++;
          if (cyc - mark != e.gap) begin
            tests_failed++;
            $display("FAIL sb_timing: code %h after %0d cycles expected %0d", e.code, cyc - mark, e.gap);
          end
        end
      end
      prev_asci = record_asci;
      mark = cyc;
    end
  end

  task automatic push_exp(input logic [7:0] code, input logic play, input int gap);
    exp_t e;
    e.code = code;
    e.play = play;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_5MHz);
      #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d expected outputs never appeared", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_level(input int level, input int budget);
    int n = 0;
    while (exp_q.size() > level && n < budget) begin
      @(negedge clk_5MHz);
      #1;
      n++;
    end
  endtask

  task automatic record_take();
    @(negedge clk_5MHz);
    record   = 1'b1;
    ps2_asci = take_q[0];
    repeat (5) @(negedge clk_5MHz);
    for (int i = 1; i < take_q.size(); i++) begin
      ps2_asci = take_q[i];
      repeat (4) @(negedge clk_5MHz);
    end
    record = 1'b0;
    @(negedge clk_5MHz);
  endtask

  task automatic start_play(input logic lp);
    @(negedge clk_5MHz);
    loop   = lp;
    replay = 1'b1;
    mark   = cyc;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    record   = 1'b0;
    replay   = 1'b0;
    loop     = 1'b0;
    ps2_asci = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_5MHz);
    tests_run++;
    if (record_asci !== 8'h00 || playing !== 1'b0 || rec_len !== 3'd0 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: asci=%h playing=%b rec_len=%0d full=%b expected 00/0/0/0",
               record_asci, playing, rec_len, full);
    end
    rst_n = 1'b1;
    @(negedge clk_5MHz);
    armed = 1'b1;
  endtask

  task automatic test_basic_take();
    take_q = '{8'h41, 8'h42, 8'h43};
    record_take();
    tests_run++;
    if (rec_len !== 3'd3 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_len: rec_len=%0d full=%b expected 3/0", rec_len, full);
    end
    push_exp(8'h41, 1'b1, 5);
    push_exp(8'h42, 1'b1, 4);
    push_exp(8'h43, 1'b1, 4);
    push_exp(8'h00, 1'b0, 4);
    start_play(1'b0);
    tests_run++;
    @(negedge clk_5MHz);
    if (playing !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_playing: got %b expected 1", playing);
    end
    wait_drain(40);
    replay = 1'b0;
    tests_run++;
    if (rec_len !== 3'd3) begin
      tests_failed++;
      $display("FAIL basic_len_kept: rec_len=%0d expected 3", rec_len);
    end
  endtask

  task automatic test_full();
    take_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    record_take();
    tests_run++;
    if (rec_len !== 3'd4 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_len: rec_len=%0d full=%b expected 4/1", rec_len, full);
    end
    push_exp(8'h01, 1'b1, 5);
    push_exp(8'h02, 1'b1, 4);
    push_exp(8'h03, 1'b1, 4);
    push_exp(8'h04, 1'b1, 4);
    push_exp(8'h00, 1'b0, 4);
    start_play(1'b0);
    wait_drain(60);
    replay = 1'b0;
  endtask

  task automatic test_loop();
    take_q = '{8'h10, 8'h20};
    record_take();
    tests_run++;
    if (rec_len !== 3'd2) begin
      tests_failed++;
      $display("FAIL loop_len: rec_len=%0d expected 2", rec_len);
    end
    push_exp(8'h10, 1'b1, 5);
    push_exp(8'h20, 1'b1, 4);
    push_exp(8'h10, 1'b1, 4);
    push_exp(8'h20, 1'b1, 4);
    push_exp(8'h00, 1'b0, 4);
    start_play(1'b1);
    wait_level(2, 60);
    loop = 1'b0;
    wait_drain(40);
    replay = 1'b0;
  endtask

  task automatic test_record_abort();
    push_exp(8'h10, 1'b1, 5);
    push_exp(8'h00, 1'b0, 1);
    start_play(1'b0);
    wait_level(1, 40);
    record = 1'b1;
    wait_drain(20);
    tests_run++;
    if (rec_len !== 3'd0 || playing !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: rec_len=%0d playing=%b expected 0/0", rec_len, playing);
    end
    record = 1'b0;
    repeat (12) @(negedge clk_5MHz);
    tests_run++;
    if (playing !== 1'b0 || record_asci !== 8'h00) begin
      tests_failed++;
      $display("FAIL empty_replay: playing=%b asci=%h expected 0/00", playing, record_asci);
    end
    replay = 1'b0;
  endtask

  task automatic test_reset_mid_play();
    take_q = '{8'h55, 8'h66, 8'h77};
    record_take();
    push_exp(8'h55, 1'b1, 5);
    push_exp(8'h00, 1'b0, 0);
    start_play(1'b0);
    wait_level(1, 40);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (record_asci !== 8'h00 || playing !== 1'b0 || rec_len !== 3'd0 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_play: asci=%h playing=%b rec_len=%0d full=%b expected 00/0/0/0",
               record_asci, playing, rec_len, full);
    end
    wait_drain(10);
    @(negedge clk_5MHz);
    rst_n = 1'b1;
    repeat (12) @(negedge clk_5MHz);
    tests_run++;
    if (playing !== 1'b0 || record_asci !== 8'h00) begin
      tests_failed++;
      $display("FAIL replay_after_reset: playing=%b asci=%h expected 0/00", playing, record_asci);
    end
    replay = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_take();
    test_full();
    test_loop();
    test_record_abort();
    test_reset_mid_play();
    repeat (4) @(negedge clk_5MHz);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
